cpu_mc: RTL and testbench

//  Parametrised multicycle successor core: fetches 2-byte instructions over a ready-handshaked bus.

---
 rtl/cpu_mc_pkg.sv | 37 +++
 rtl/cpu_mc_alu.sv | 35 +++
 rtl/cpu_mc.sv | 97 +++++++++
 tb/tb_cpu_mc.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mc_pkg.sv
// cpu_mc_pkg: shared FSM/opcode types, instruction-group masks and branch-condition helper
package cpu_mc_pkg;
  typedef enum logic [2:0] {S_F0, S_F1, S_EX, S_MEM, S_HLT} state_e;
  typedef enum logic [3:0] {
    ALU_ADD = 4'h0, ALU_ADC = 4'h1, ALU_SUB = 4'h2, ALU_SBC = 4'h3, ALU_AND = 4'h4,
    ALU_OR = 4'h6, ALU_XOR = 4'h8, ALU_MOV = 4'hA, ALU_CMP = 4'hC
  } alu_op_e;
  typedef enum logic [3:0] {
    BR_EQ, BR_NE, BR_LT, BR_GE, BR_CS, BR_VS, BR_MI, BR_CC, BR_VC, BR_PL, BR_CS2, BR_CC2, BR_AL
  } br_cond_e;
  typedef enum logic [2:0] {
    M_CLC = 3'd0, M_CLZ = 3'd1, M_CLO = 3'd2, M_CLN = 3'd3, M_NOP = 3'd6, M_HLT = 3'd7
  } misc_op_e;
  typedef struct packed {logic c; logic z; logic v; logic n;} flags_t;
  // ALU-const is any ir0 whose low two bits are not both set
  localparam logic [7:0] ALC_MASK = 8'h03;
  localparam logic [7:0] BR_MASK = 8'h07, BR_MATCH = 8'h03;
  localparam logic [7:0] ALR_MASK = 8'h0F, ALR_MATCH = 8'h07;
  localparam logic [7:0] MEM_MASK = 8'h1F, MEM_MATCH = 8'h0F;
  localparam logic [7:0] MISC_MASK = 8'h1F, MISC_MATCH = 8'h1F;
  function automatic logic cond_true(input logic [3:0] c, input flags_t f);
    case (br_cond_e'(c))
      BR_EQ: return f.z;
      BR_NE: return !f.z;
      BR_LT: return f.n ^ f.v;
      BR_GE: return !(f.n ^ f.v);
      BR_CS, BR_CS2: return f.c;
      BR_VS: return f.v;
      BR_MI: return f.n;
      BR_CC, BR_CC2: return !f.c;
      BR_VC: return !f.v;
      BR_PL: return !f.n;
      BR_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/cpu_mc_alu.sv
// cpu_mc_alu: combinational ALU giving result, C/V/Z/N, writeback enable and legal-op flag
module cpu_mc_alu import cpu_mc_pkg::*; #(
  parameter int W = 8
)(
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  input  alu_op_e      i_op,
  output logic [W-1:0] o_res,
  output logic         o_c,
  output logic         o_v,
  output logic         o_z,
  output logic         o_n,
  output logic         o_we,
  output logic         o_ok
);
  logic w_sub, w_arith, w_cin;
  logic [W:0] w_sum;
  always_comb begin
    w_sub = i_op inside {ALU_SUB, ALU_SBC, ALU_CMP};
    w_arith = w_sub || i_op inside {ALU_ADD, ALU_ADC};
    w_cin = i_cin && (i_op == ALU_ADC || i_op == ALU_SBC);
    // bit W of the W+1-bit result is carry for add and borrow for subtract
    w_sum = w_sub ? {1'b0, i_a} - {1'b0, i_b} - (W+1)'(w_cin)
                  : {1'b0, i_a} + {1'b0, i_b} + (W+1)'(w_cin);
    o_res = w_arith ? w_sum[W-1:0] : i_op == ALU_AND ? i_a & i_b : i_op == ALU_OR ? i_a | i_b :
            i_op == ALU_XOR ? i_a ^ i_b : i_op == ALU_MOV ? i_b : '0;
    o_c = w_arith ? w_sum[W] : i_cin;
    o_v = w_arith && ((i_a[W-1] ^ i_b[W-1]) == w_sub) && (o_res[W-1] != i_a[W-1]);
    o_z = o_res == '0;
    o_n = o_res[W-1];
    o_ok = w_arith || i_op inside {ALU_AND, ALU_OR, ALU_XOR, ALU_MOV};
    o_we = o_ok && i_op != ALU_CMP;
  end
endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: multicycle core fetching 2-byte instructions over a ready-handshaked bus
module cpu_mc import cpu_mc_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int NREGS = 16,
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h2000
)(
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_rd,
  output logic              bus_wr,
  input  logic              bus_ready,
  output logic              halt,
  output logic              illegal
);
  localparam int RW = $clog2(NREGS);
  state_e r_state, w_next;
  logic [ADDR_W-1:0] r_pc, w_maddr, w_target;
  logic [7:0] r_ir0, r_ir1;
  logic [DATA_W-1:0] r_regs [NREGS];
  flags_t r_flags;
  logic r_illegal;
  logic w_alc, w_alr, w_br, w_mem, w_misc, w_st, w_take;
  logic w_c, w_v, w_z, w_n, w_we, w_ok;
  logic [3:0] w_op;
  logic [RW-1:0] w_rd, w_rs, w_plo, w_phi;
  logic [DATA_W-1:0] w_b, w_res;
  logic [2*DATA_W-1:0] w_ptr;
  misc_op_e w_mop;
  always_comb begin
    w_alc = (r_ir0 & ALC_MASK) != ALC_MASK;
    w_br = (r_ir0 & BR_MASK) == BR_MATCH;
    w_alr = (r_ir0 & ALR_MASK) == ALR_MATCH;
    w_mem = (r_ir0 & MEM_MASK) == MEM_MATCH;
    w_misc = (r_ir0 & MISC_MASK) == MISC_MATCH;
    w_st = r_ir0[5];
    w_mop = misc_op_e'(r_ir0[7:5]);
    w_op = w_alc ? r_ir0[3:0] : r_ir0[7:4];
    w_rd = RW'(w_alc ? r_ir0[7:4] : r_ir1[3:0]);
    w_rs = RW'(r_ir1[7:4]);
    w_b = w_alc ? DATA_W'(r_ir1) : r_regs[w_rs];
    // pointer pair Pp lives in r(2p+9):r(2p+8)
    w_plo = RW'({1'b1, r_ir1[5:4], 1'b0});
    w_phi = RW'({1'b1, r_ir1[5:4], 1'b1});
    w_ptr = {r_regs[w_phi], r_regs[w_plo]};
    w_maddr = w_ptr[ADDR_W-1:0];
    w_take = cond_true(r_ir0[6:3], r_flags);
    w_target = r_pc - ADDR_W'(2) + ADDR_W'($signed({r_ir0[7], r_ir1}));
    w_next = r_state;
    if ((r_state == S_F0) && bus_ready) w_next = S_F1;
    if ((r_state == S_F1) && bus_ready) w_next = S_EX;
    if (r_state == S_EX) w_next = w_mem ? S_MEM : (w_misc && w_mop == M_HLT) ? S_HLT : S_F0;
    if ((r_state == S_MEM) && bus_ready) w_next = S_F0;
    bus_rd = reset && (r_state == S_F0 || r_state == S_F1 || (r_state == S_MEM && !w_st));
    bus_wr = reset && r_state == S_MEM && w_st;
    bus_addr = r_state == S_MEM ? w_maddr : r_pc;
    bus_wdata = r_regs[w_rd];
    halt = r_state == S_HLT;
    illegal = r_illegal;
  end
  cpu_mc_alu #(.W(DATA_W)) u_alu (
    .i_a(r_regs[w_rd]), .i_b(w_b), .i_cin(r_flags.c), .i_op(alu_op_e'(w_op)),
    .o_res(w_res), .o_c(w_c), .o_v(w_v), .o_z(w_z), .o_n(w_n), .o_we(w_we), .o_ok(w_ok)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_F0;
      r_pc <= RESET_PC;
      r_ir0 <= '0;
      r_ir1 <= '0;
      r_flags <= '0;
      r_illegal <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_F0 && bus_ready) r_ir0 <= bus_rdata[7:0];
      if (r_state == S_F1 && bus_ready) r_ir1 <= bus_rdata[7:0];
      if ((r_state == S_F0 || r_state == S_F1) && bus_ready) r_pc <= r_pc + ADDR_W'(1);
      if (r_state == S_EX && (w_alc || w_alr)) begin
        if (w_ok) r_flags <= {w_c, w_z, w_v, w_n};
        if (w_we) r_regs[w_rd] <= w_res;
        if (!w_ok) r_illegal <= 1'b1;
      end
      if (r_state == S_EX && w_br && w_take) r_pc <= w_target;
      if (r_state == S_EX && w_misc) begin
        if (w_mop == M_CLC) r_flags.c <= 1'b0;
        if (w_mop == M_CLZ) r_flags.z <= 1'b0;
        if (w_mop == M_CLO) r_flags.v <= 1'b0;
        if (w_mop == M_CLN) r_flags.n <= 1'b0;
      end
      if (r_state == S_MEM && bus_ready && !w_st) r_regs[w_rd] <= bus_rdata;
    end
  end
endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: table-driven ALU vectors plus directed fetch/wait/branch/LD-ST/halt sequences
module tb_cpu_mc;
  logic clk = 1'b0, reset = 1'b0, rdy = 1'b1;
  logic [15:0] bus_addr;
  logic [7:0] bus_rdata, bus_wdata;
  logic bus_rd, bus_wr, halt, illegal;
  logic [7:0] mem [65536];
  logic [15:0] wr_addr;
  logic [7:0] wr_data;
  int n_chk = 0, n_err = 0;
  cpu_mc dut (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_rdata(bus_rdata), .bus_wdata(bus_wdata),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_ready(rdy), .halt(halt), .illegal(illegal)
  );
  always #5 clk = ~clk;
  assign bus_rdata = mem[bus_addr];
  always @(posedge clk) begin
    if (reset && bus_wr && rdy) begin
      mem[bus_addr] = bus_wdata;
      wr_addr = bus_addr;
      wr_data = bus_wdata;
    end
  end
  // prelude(p0,p1); MOV r1,a; op(o0,o1); HLT -> expected r1, flags {c,z,v,n}, illegal
  typedef struct packed {
    logic [7:0] p0, p1, o0, o1, a, r1;
    logic [3:0] fl;
    logic ill;
  } vec_t;
  typedef struct packed {
    logic [7:0] zv, b0, b1;
    logic [15:0] exp;
  } bv_t;
  vec_t vecs [15];
  bv_t bvs [5];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [15:0] a, input logic [7:0] b0, input logic [7:0] b1);
    mem[a] = b0;
    mem[16'(a + 16'd1)] = b1;
  endtask
  task automatic clear_prog();
    for (int i = 16'h2000; i < 16'h2040; i++) mem[i] = 8'h00;
    mem[16'h3000] = 8'h00;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
  endtask
  task automatic wait_halt(input string nm);
    for (int k = 0; k < 200 && !halt; k++) step();
    chk(nm, halt, 1);
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    wr_addr = '0;
    wr_data = '0;
    vecs[0]  = '{8'hDF, 8'h00, 8'h10, 8'h01, 8'h7F, 8'h80, 4'b0011, 1'b0};
    vecs[1]  = '{8'hDF, 8'h00, 8'h1C, 8'h80, 8'h80, 8'h80, 4'b0100, 1'b0};
    vecs[2]  = '{8'hDF, 8'h00, 8'h10, 8'h01, 8'hFF, 8'h00, 4'b1100, 1'b0};
    vecs[3]  = '{8'h22, 8'h01, 8'h11, 8'h20, 8'h10, 8'h31, 4'b0000, 1'b0};
    vecs[4]  = '{8'hDF, 8'h00, 8'h12, 8'h05, 8'h03, 8'hFE, 4'b1001, 1'b0};
    vecs[5]  = '{8'hDF, 8'h00, 8'h12, 8'h01, 8'h80, 8'h7F, 4'b0010, 1'b0};
    vecs[6]  = '{8'h22, 8'h01, 8'h37, 8'h01, 8'h10, 8'h0F, 4'b0000, 1'b0};
    vecs[7]  = '{8'h22, 8'h01, 8'h14, 8'h0F, 8'hF0, 8'h00, 4'b1100, 1'b0};
    vecs[8]  = '{8'hDF, 8'h00, 8'h16, 8'h81, 8'h40, 8'hC1, 4'b0001, 1'b0};
    vecs[9]  = '{8'h22, 8'h01, 8'h87, 8'h21, 8'h0F, 8'hF0, 4'b1001, 1'b0};
    vecs[10] = '{8'hDF, 8'h00, 8'h15, 8'h00, 8'h33, 8'h33, 4'b0000, 1'b1};
    vecs[11] = '{8'hDF, 8'h00, 8'h1A, 8'h00, 8'h55, 8'h00, 4'b0100, 1'b0};
    vecs[12] = '{8'h22, 8'h01, 8'h1F, 8'h00, 8'h77, 8'h77, 4'b0000, 1'b0};
    vecs[13] = '{8'h22, 8'h01, 8'h17, 8'h21, 8'h01, 8'h01, 4'b1000, 1'b0};
    vecs[14] = '{8'hDF, 8'h00, 8'h7F, 8'h00, 8'h80, 8'h80, 4'b0000, 1'b0};
    bvs[0] = '{8'h00, 8'h83, 8'hFE, 16'h200E};
    bvs[1] = '{8'h01, 8'h83, 8'hFE, 16'h2012};
    bvs[2] = '{8'h01, 8'h63, 8'h20, 16'h2030};
    bvs[3] = '{8'h00, 8'h6B, 8'h20, 16'h2012};
    bvs[4] = '{8'h01, 8'h8B, 8'hF0, 16'h2000};
    // first fetch address, reset-time bus idle, exact 3-clock ALU latency
    clear_prog();
    load(16'h2000, 8'h10, 8'h05);
    load(16'h2002, 8'hFF, 8'h00);
    reset = 1'b0;
    step();
    step();
    chk("rst bus_rd", bus_rd, 0);
    chk("rst bus_wr", bus_wr, 0);
    chk("rst halt", halt, 0);
    chk("rst illegal", illegal, 0);
    reset = 1'b1;
    #1;
    chk("first rd", bus_rd, 1);
    chk("first addr", bus_addr, 16'h2000);
    step();
    step();
    chk("r1 before EX", dut.r_regs[1], 8'h00);
    step();
    chk("r1 after 3clk", dut.r_regs[1], 8'h05);
    chk("pc after 3clk", dut.r_pc, 16'h2002);
    for (int i = 0; i < 15; i++) begin
      clear_prog();
      load(16'h2000, vecs[i].p0, vecs[i].p1);
      load(16'h2002, 8'h1A, vecs[i].a);
      load(16'h2004, vecs[i].o0, vecs[i].o1);
      load(16'h2006, 8'hFF, 8'h00);
      do_reset();
      wait_halt($sformatf("v%0d halt", i));
      chk($sformatf("v%0d r1", i), dut.r_regs[1], vecs[i].r1);
      chk($sformatf("v%0d flags", i), dut.r_flags, vecs[i].fl);
      chk($sformatf("v%0d illegal", i), illegal, vecs[i].ill);
    end
    // wait states on F1: address/request held, result just delayed
    clear_prog();
    load(16'h2000, 8'h1A, 8'h7F);
    load(16'h2002, 8'hFF, 8'h00);
    do_reset();
    step();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wait%0d rd", k), bus_rd, 1);
      chk($sformatf("wait%0d addr", k), bus_addr, 16'h2001);
      step();
    end
    rdy = 1'b1;
    #1;
    step();
    chk("wait r1 in EX", dut.r_regs[1], 8'h00);
    step();
    chk("wait r1", dut.r_regs[1], 8'h7F);
    chk("wait pc", dut.r_pc, 16'h2002);
    // reset while a fetch is pending drops the request immediately
    rdy = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst rd", bus_rd, 0);
    step();
    rdy = 1'b1;
    // branches from 2010: taken/not-taken, forward, never, backward
    for (int i = 0; i < 5; i++) begin
      clear_prog();
      load(16'h2000, 8'h1A, bvs[i].zv);
      for (int a = 16'h2002; a < 16'h2010; a += 2) load(16'(a), 8'hDF, 8'h00);
      load(16'h2010, bvs[i].b0, bvs[i].b1);
      do_reset();
      for (int k = 0; k < 100; k++) begin
        if (bus_rd && bus_addr == 16'h2010) break;
        step();
      end
      chk($sformatf("br%0d reach", i), bus_addr, 16'h2010);
      step();
      step();
      step();
      chk($sformatf("br%0d rd", i), bus_rd, 1);
      chk($sformatf("br%0d target", i), bus_addr, bvs[i].exp);
    end
    // ST r2,[P0] then LD r3,[P0] with P0=3000
    clear_prog();
    load(16'h2000, 8'h8A, 8'h00);
    load(16'h2002, 8'h9A, 8'h30);
    load(16'h2004, 8'h2A, 8'hAA);
    load(16'h2006, 8'h2F, 8'h02);
    load(16'h2008, 8'h0F, 8'h03);
    load(16'h200A, 8'hFF, 8'h00);
    do_reset();
    wait_halt("ldst halt");
    chk("st addr", wr_addr, 16'h3000);
    chk("st data", wr_data, 8'hAA);
    chk("st mem", mem[16'h3000], 8'hAA);
    chk("ld r3", dut.r_regs[3], 8'hAA);
    chk("ldst flags", dut.r_flags, 4'b0001);
    // illegal op, then HLT, then reset clears both
    clear_prog();
    load(16'h2000, 8'h15, 8'h00);
    load(16'h2002, 8'hFF, 8'h00);
    do_reset();
    step();
    step();
    step();
    chk("ill flag", illegal, 1);
    chk("ill next addr", bus_addr, 16'h2002);
    chk("ill next rd", bus_rd, 1);
    step();
    step();
    step();
    chk("hlt halt", halt, 1);
    begin
      logic busy;
      busy = 1'b0;
      for (int k = 0; k < 4; k++) begin
        busy = busy | bus_rd | bus_wr;
        step();
      end
      chk("hlt no bus", busy, 0);
    end
    reset = 1'b0;
    step();
    chk("post rst halt", halt, 0);
    chk("post rst illegal", illegal, 0);
    reset = 1'b1;
    #1;
    chk("post rst rd", bus_rd, 1);
    chk("post rst addr", bus_addr, 16'h2000);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
